prime_factor_seq: RTL and testbench

//  Factorises an unsigned number by trial division over the first nine primes (2..23).

---
 rtl/factor_pkg.sv | 20 ++
 rtl/prime_divider.sv | 50 +++++
 rtl/prime_factor_seq.sv | 138 +++++++++++++
 tb/tb_prime_factor_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared constants, state encoding and prime lookup for the trial-division factoriser.
package factor_pkg;

  localparam int NPRIME = 9;
  localparam logic [3:0] FIDX_DASH  = 4'h0;
  localparam logic [3:0] FIDX_BLANK = 4'hF;
  localparam logic [4:0] PRIME_TBL [1:9] = '{5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd13, 5'd17, 5'd19, 5'd23};

  typedef enum logic [2:0] {IDLE, LOAD, DIV, SHOW, FIN} state_e;

  // Out-of-range indices map to 0; the FSM never starts the divider with them.
  function automatic logic [4:0] prime_of(input logic [3:0] k);
    logic [4:0] p;
    p = 5'd0;
    for (int i = 1; i <= NPRIME; i++)
      if (k == 4'(i)) p = PRIME_TBL[i];
    return p;
  endfunction

endpackage

// File: rtl/prime_divider.sv
// Serial restoring divider: WIDTH-bit dividend by a 5-bit divisor, one quotient bit per cycle.
module prime_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             GO,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [4:0]       DIVISOR,
  output logic [WIDTH-1:0] QUO,
  output logic [4:0]       REM,
  output logic             RDY
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [4:0]    dsr;
  logic [CW-1:0] cnt;
  logic [5:0]    trial;

  // QUO doubles as the dividend shift register; quotient bits enter from the right.
  always_comb trial = {REM, QUO[WIDTH-1]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      QUO <= '0;
      REM <= '0;
      dsr <= '0;
      cnt <= '0;
      RDY <= 1'b0;
    end else if (GO) begin
      QUO <= DIVIDEND;
      REM <= '0;
      dsr <= DIVISOR;
      cnt <= CW'(WIDTH);
      RDY <= 1'b0;
    end else if (cnt != '0) begin
      if (trial >= {1'b0, dsr}) begin
        REM <= 5'(trial - {1'b0, dsr});
        QUO <= {QUO[WIDTH-2:0], 1'b1};
      end else begin
        REM <= trial[4:0];
        QUO <= {QUO[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) RDY <= 1'b1;
    end
  end

endmodule

// File: rtl/prime_factor_seq.sv
// Trial-division factoriser emitting one prime index per factor, each held DWELL cycles.
// Optional FCNT factor counter output when FACTOR_COUNT_EN is defined.
module prime_factor_seq
  import factor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 50_000_000
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic [WIDTH-1:0] NUM,
  output logic [3:0]       FIDX,
  output logic             VALID,
  output logic             BUSY,
  output logic             DONE
`ifdef FACTOR_COUNT_EN
  ,
  output logic [3:0]       FCNT
`endif
);

  localparam int DW = $clog2(DWELL + 1);

  state_e           state;
  logic [WIDTH-1:0] n;
  logic [3:0]       k;
  logic             first;
  logic             fin_flag;
  logic [DW-1:0]    dwell;
  logic             go;
  logic [WIDTH-1:0] dv_quo;
  logic [4:0]       dv_rem;
  logic             dv_rdy;
  logic             n_low;
  logic             k_over;

  always_comb begin
    n_low  = (n < WIDTH'(2));
    k_over = (k > 4'(NPRIME));
    go     = (state == LOAD) && !n_low && !k_over;
  end

  prime_divider #(.WIDTH(WIDTH)) u_div (
    .CLK      (CLK),
    .nRST     (nRST),
    .GO       (go),
    .DIVIDEND (n),
    .DIVISOR  (prime_of(k)),
    .QUO      (dv_quo),
    .REM      (dv_rem),
    .RDY      (dv_rdy)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      FIDX     <= FIDX_BLANK;
      VALID    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      n        <= '0;
      k        <= 4'd1;
      first    <= 1'b0;
      fin_flag <= 1'b0;
      dwell    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          n        <= NUM;
          k        <= 4'd1;
          BUSY     <= 1'b1;
          first    <= 1'b1;
          fin_flag <= 1'b0;
          state    <= LOAD;
        end
        // A dash covers both "nothing to factor" and "leftover prime above 23".
        LOAD: begin
          if ((n_low && first) || (!n_low && k_over)) begin
            FIDX     <= FIDX_DASH;
            VALID    <= 1'b1;
            dwell    <= DW'(DWELL);
            fin_flag <= 1'b1;
            state    <= SHOW;
          end else if (n_low) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= FIN;
          end else begin
            state <= DIV;
          end
        end
        DIV: if (dv_rdy) begin
          if (dv_rem == 5'd0) begin
            n     <= dv_quo;
            FIDX  <= k;
            VALID <= 1'b1;
            dwell <= DW'(DWELL);
            first <= 1'b0;
            state <= SHOW;
          end else begin
            k     <= k + 4'd1;
            state <= LOAD;
          end
        end
        SHOW: begin
          if (dwell == DW'(1)) begin
            VALID <= 1'b0;
            if (fin_flag) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= FIN;
            end else begin
              state <= LOAD;
            end
          end else begin
            dwell <= dwell - 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FACTOR_COUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      FCNT <= 4'd0;
    else if (state == IDLE && START)
      FCNT <= 4'd0;
    else if (state == DIV && dv_rdy && dv_rem == 5'd0 && FCNT != 4'hF)
      FCNT <= FCNT + 4'd1;
  end
`endif

endmodule

// File: tb/tb_prime_factor_seq.sv
// Bench for prime_factor_seq (WIDTH=8, DWELL=4): table vectors, random numbers against a
// plain-arithmetic factorisation model, and hand-written reset / ignored-START sequences.
module tb_prime_factor_seq;

  localparam int WIDTH = 8;
  localparam int DWELL = 4;
  localparam int LIMIT = 600;
  localparam int MAX_LAT = 2 + 9 * (WIDTH + 2);

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             START = 1'b0;
  logic [WIDTH-1:0] NUM = '0;
  logic [3:0]       FIDX;
  logic             VALID;
  logic             BUSY;
  logic             DONE;
`ifdef FACTOR_COUNT_EN
  logic [3:0]       FCNT;
`endif

  prime_factor_seq #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .START (START),
    .NUM   (NUM),
    .FIDX  (FIDX),
    .VALID (VALID),
    .BUSY  (BUSY),
    .DONE  (DONE)
`ifdef FACTOR_COUNT_EN
    ,
    .FCNT  (FCNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int exp_q[$];

  typedef struct {
    logic [7:0]  num;
    int          len;
    logic [31:0] seq;   // nibble i = i-th expected index
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: factor by the first nine primes with ordinary arithmetic.
  task automatic model(input int num);
    int m;
    int primes[9] = '{2, 3, 5, 7, 11, 13, 17, 19, 23};
    exp_q.delete();
    m = num;
    if (m <= 1) begin
      exp_q.push_back(0);
      return;
    end
    for (int i = 0; i < 9; i++)
      while (m % primes[i] == 0) begin
        exp_q.push_back(i + 1);
        m = m / primes[i];
      end
    if (m > 1) exp_q.push_back(0);
  endtask

  // Starts one factorisation, collects emitted indices into got_q, checks timing/handshake.
  task automatic run_seq(input logic [7:0] num, input bit poke, input int exp_last, input int exp_cnt);
    int  cyc;
    int  len;
    int  first_v;
    bit  prev_v;
    bit  done_seen;
    int  bad_dwell;
    cyc = 0; len = 0; first_v = -1; prev_v = 0; done_seen = 0; bad_dwell = 0;
    got_q.delete();
    @(negedge CLK);
    START = 1'b1;
    NUM   = num;
    @(negedge CLK);
    START = 1'b0;
    NUM   = 8'($urandom);
    check("busy_after_start", BUSY, 1);
    while (!done_seen && cyc < LIMIT) begin
      if (VALID) begin
        if (!prev_v) begin
          got_q.push_back(int'(FIDX));
          if (first_v < 0) first_v = cyc;
        end
        len++;
      end else if (prev_v) begin
        if (len != DWELL) bad_dwell++;
        len = 0;
      end
      prev_v = VALID;
      if (DONE) done_seen = 1;
      else begin
        if (poke && cyc == 20) begin
          START = 1'b1;
          NUM   = 8'd12;
        end else begin
          START = 1'b0;
        end
        @(negedge CLK);
        cyc++;
      end
    end
    START = 1'b0;
    check("done_reached", done_seen, 1);
    check("dwell_lengths_bad", bad_dwell, 0);
    check("first_valid_in_budget", (first_v >= 0 && first_v + 1 <= MAX_LAT), 1);
    check("busy_low_at_done", BUSY, 0);
    check("fidx_at_done", FIDX, exp_last);
`ifdef FACTOR_COUNT_EN
    check("fcnt_at_done", FCNT, exp_cnt);
`else
    if (exp_cnt < 0) check("fcnt_arg", exp_cnt, 0);
`endif
    @(negedge CLK);
    check("done_one_cycle", DONE, 0);
    check("fidx_holds", FIDX, exp_last);
    check("valid_idle", VALID, 0);
  endtask

  function automatic int nz_count();
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i] != 0) c++;
    return (c > 15) ? 15 : c;
  endfunction

  task automatic compare_q(input string name, input int len, input logic [31:0] seq);
    logic [31:0] t;
    check({name, "_len"}, got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) begin
      t = seq >> (4 * i);
      check({name, "_idx"}, got_q[i], {28'd0, t[3:0]});
    end
  endtask

  task automatic compare_model(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_idx"}, got_q[i], exp_q[i]);
  endtask

  vec_t vecs[10];

  initial begin
    int nv;
    int cyc;
    bit prev;
    logic [31:0] t;

    vecs[0] = '{8'd12,  3, 32'h0000_0211};
    vecs[1] = '{8'd210, 4, 32'h0000_4321};
    vecs[2] = '{8'd253, 2, 32'h0000_0095};
    vecs[3] = '{8'd58,  2, 32'h0000_0001};
    vecs[4] = '{8'd1,   1, 32'h0000_0000};
    vecs[5] = '{8'd0,   1, 32'h0000_0000};
    vecs[6] = '{8'd128, 7, 32'h0111_1111};
    vecs[7] = '{8'd255, 3, 32'h0000_0732};
    vecs[8] = '{8'd232, 4, 32'h0000_0111};
    vecs[9] = '{8'd9,   2, 32'h0000_0022};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_fidx", FIDX, 4'hF);
    check("rst_valid", VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
`ifdef FACTOR_COUNT_EN
    check("rst_fcnt", FCNT, 0);
`endif
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 10; v++) begin
      model(int'(vecs[v].num));
      t = vecs[v].seq >> (4 * (vecs[v].len - 1));
      run_seq(vecs[v].num, 1'b0, int'(t[3:0]), nz_count());
      compare_q($sformatf("vec%0d", vecs[v].num), vecs[v].len, vecs[v].seq);
    end

    // START with a different NUM during a run must be ignored.
    model(210);
    run_seq(8'd210, 1'b1, 4, 4);
    compare_q("ignored_start", 4, 32'h0000_4321);

    for (int r = 0; r < 12; r++) begin
      logic [7:0] rn;
      rn = 8'($urandom_range(0, 255));
      model(int'(rn));
      run_seq(rn, 1'b0, exp_q[exp_q.size() - 1], nz_count());
      compare_model($sformatf("rand%0d", rn));
    end

    // Asynchronous reset during the second SHOW of NUM=12.
    @(negedge CLK);
    START = 1'b1;
    NUM   = 8'd12;
    @(negedge CLK);
    START = 1'b0;
    nv = 0; cyc = 0; prev = 0;
    while (nv < 2 && cyc < LIMIT) begin
      if (VALID && !prev) nv++;
      prev = VALID;
      if (nv < 2) begin
        @(negedge CLK);
        cyc++;
      end
    end
    check("rst_mid_second_show", nv, 2);
    @(negedge CLK);
    check("rst_mid_valid_before", VALID, 1);
    nRST = 1'b0;
    #1;
    check("rst_mid_fidx", FIDX, 4'hF);
    check("rst_mid_valid", VALID, 0);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_done", DONE, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    model(9);
    run_seq(8'd9, 1'b0, 2, 2);
    compare_q("after_rst_9", 2, 32'h0000_0022);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
